mdu_sequencer: RTL and testbench

//  Sequences the RV32M multiply/divide unit next to the main ALU in EX. Accepts one M-ext op
//  (funct3 selects), runs 1-cycle multiply or XLEN-iteration restoring divide, stalls the

---
 rtl/mdu_sequencer_if.sv | 24 ++
 rtl/mdu_sequencer.sv | 133 +++++++++++++
 tb/tb_mdu_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/mdu_sequencer_if.sv
// Handshake and operand bus between the EX stage and the RV32M multiply/divide sequencer.
interface mdu_sequencer_if #(
  parameter int unsigned XLEN = 32
);
  logic            start;
  logic            flush;
  logic [2:0]      funct3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] result;
  logic            done;
  logic            busy;
  logic            stall;

  modport master (
    output start, flush, funct3, op_a, op_b,
    input  result, done, busy, stall
  );

  modport slave (
    input  start, flush, funct3, op_a, op_b,
    output result, done, busy, stall
  );
endinterface

// File: rtl/mdu_sequencer.sv
// RV32M multiply/divide sequencer: single-cycle multiply, XLEN-step restoring divide,
// divide-by-zero / signed-overflow fast paths, flush abort.
module mdu_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input logic          clk,
  input logic          rst,
  mdu_sequencer_if.slave mdu
);
  localparam int unsigned CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [1:0]      f3_q, f3_d;
  logic [XLEN-1:0] a_q, a_d, b_q, b_d, rem_q, rem_d, result_q, result_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            negq_q, negq_d, negr_q, negr_d;

  logic            sa_mul, sb_mul, sa_in, sb_in, div_ge;
  logic [2*XLEN-1:0] a_x, b_x, prod;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] div_sub, mul_res, quot_fix, rem_fix;

  // a_q doubles as the quotient shift register once a divide is running.
  assign sa_mul  = (f3_q != 2'b11);
  assign sb_mul  = ~f3_q[1];
  assign a_x     = {{XLEN{sa_mul & a_q[XLEN-1]}}, a_q};
  assign b_x     = {{XLEN{sb_mul & b_q[XLEN-1]}}, b_q};
  assign prod    = a_x * b_x;
  assign mul_res = (f3_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  assign rem_sh  = {rem_q, a_q[XLEN-1]};
  assign div_ge  = rem_sh >= {1'b0, b_q};
  assign div_sub = rem_sh[XLEN-1:0] - b_q;

  assign quot_fix = negq_q ? -a_q : a_q;
  assign rem_fix  = negr_q ? -rem_q : rem_q;

  assign sa_in = ~mdu.funct3[0] & mdu.op_a[XLEN-1];
  assign sb_in = ~mdu.funct3[0] & mdu.op_b[XLEN-1];

  always_comb begin
    state_d  = state_q;
    f3_d     = f3_q;
    a_d      = a_q;
    b_d      = b_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;
    unique case (state_q)
      S_IDLE: begin
        if (mdu.start) begin
          f3_d   = mdu.funct3[1:0];
          a_d    = mdu.op_a;
          b_d    = mdu.op_b;
          rem_d  = '0;
          cnt_d  = '0;
          negq_d = 1'b0;
          negr_d = 1'b0;
          if (!mdu.funct3[2]) begin
            state_d = S_MUL;
          end else if (mdu.op_b == '0) begin
            result_d = mdu.funct3[1] ? mdu.op_a : '1;
            state_d  = S_DONE;
          end else if (!mdu.funct3[0] && mdu.op_a == MIN_NEG && mdu.op_b == '1) begin
            result_d = mdu.funct3[1] ? '0 : mdu.op_a;
            state_d  = S_DONE;
          end else begin
            a_d     = sa_in ? -mdu.op_a : mdu.op_a;
            b_d     = sb_in ? -mdu.op_b : mdu.op_b;
            negq_d  = sa_in ^ sb_in;
            negr_d  = sa_in;
            state_d = S_DIV;
          end
        end
      end
      S_MUL: begin
        result_d = mul_res;
        state_d  = S_DONE;
      end
      S_DIV: begin
        rem_d = div_ge ? div_sub : rem_sh[XLEN-1:0];
        a_d   = {a_q[XLEN-2:0], div_ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(XLEN - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        result_d = f3_q[1] ? rem_fix : quot_fix;
        state_d  = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Flush wins everywhere: abandon the op and keep the last delivered result.
    if (mdu.flush) begin
      state_d  = S_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      f3_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      f3_q     <= f3_d;
      a_q      <= a_d;
      b_q      <= b_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
    end
  end

  assign mdu.result = result_q;
  assign mdu.done   = (state_q == S_DONE);
  assign mdu.busy   = (state_q != S_IDLE);
  assign mdu.stall  = mdu.start & ~mdu.done & ~mdu.flush;
endmodule

// File: tb/tb_mdu_sequencer.sv
// Scoreboard bench for mdu_sequencer: expected result and done cycle queued at issue.
module tb_mdu_sequencer;
  localparam int unsigned XLEN = 32;

  typedef struct {
    logic [31:0] res;
    int unsigned cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int unsigned cyc = 0;
  int unsigned n_total = 0;
  int unsigned n_bad = 0;
  exp_t sb[$];

  mdu_sequencer_if #(.XLEN(XLEN)) mif ();

  mdu_sequencer #(.XLEN(XLEN)) dut (
    .clk (clk),
    .rst (rst),
    .mdu (mif.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sb2, ua, ub;
    logic [63:0] p;
    logic ovf;
    sa  = longint'($signed(a));
    sb2 = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = sa * sb2; return p[31:0]; end
      3'd1: begin p = sa * sb2; return p[63:32]; end
      3'd2: begin p = sa * ub;  return p[63:32]; end
      3'd3: begin p = ua * ub;  return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb2; return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb2; return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int unsigned latency(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] b);
    if (!f3[2]) return 2;
    if (b == 0) return 1;
    if (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 2;
  endfunction

  // Every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (mif.done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", mif.result, e.res);
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  // Called at posedge+#1; returns at posedge+#1 of the cycle after done.
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int unsigned lat,
                        input bit chk_stall, input bit keep);
    int unsigned c0;
    bit seen;
    mif.start  = 1'b1;
    mif.funct3 = f3;
    mif.op_a   = a;
    mif.op_b   = b;
    c0 = cyc;
    sb.push_back('{res: exp, cyc: c0 + lat});
    seen = 1'b0;
    for (int k = 0; k < 80; k++) begin
      @(negedge clk);
      if (chk_stall) check("stall", {31'b0, mif.stall}, {31'b0, (cyc - c0) < lat});
      if (mif.done) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("done_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    if (!keep) mif.start = 1'b0;
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    int unsigned c0;
    logic [2:0]  f3;
    logic [31:0] a, b;
    rst = 1'b1;
    mif.start = 1'b0; mif.flush = 1'b0; mif.funct3 = '0; mif.op_a = '0; mif.op_b = '0;
    idle(2);
    @(negedge clk);
    check("rst_result", mif.result, 32'h0);
    check("rst_done", {31'b0, mif.done}, 32'd0);
    check("rst_busy", {31'b0, mif.busy}, 32'd0);
    mif.start = 1'b1;
    #1;
    check("rst_stall", {31'b0, mif.stall}, 32'd1);
    mif.start = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // Signed divide / remainder
    run_op(3'd4, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 34, 1'b1, 1'b0);
    run_op(3'd6, 32'd100, 32'hFFFF_FFF9, 32'h0000_0002, 34, 1'b0, 1'b0);
    run_op(3'd6, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 34, 1'b0, 1'b0);
    idle(1);

    // Fast paths
    run_op(3'd5, 32'h1234, 32'h0, 32'hFFFF_FFFF, 1, 1'b1, 1'b0);
    run_op(3'd7, 32'h1234, 32'h0, 32'h0000_1234, 1, 1'b0, 1'b0);
    run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0, 1'b0);
    run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 1'b0, 1'b0);

    // Multiplies
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2, 1'b1, 1'b0);
    run_op(3'd0, 32'h8000_0000, 32'h8000_0000, 32'h0, 2, 1'b0, 1'b0);
    run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2, 1'b0, 1'b0);
    run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2, 1'b0, 1'b0);
    idle(1);

    // Flush mid-divide, then a multiply accepted right after
    mif.start = 1'b1; mif.funct3 = 3'd5; mif.op_a = 32'd1000; mif.op_b = 32'd3;
    c0 = cyc;
    idle(10);
    mif.flush = 1'b1;
    @(negedge clk);
    check("flush_busy_before", {31'b0, mif.busy}, 32'd1);
    check("flush_stall", {31'b0, mif.stall}, 32'd0);
    @(posedge clk); #1;
    mif.flush = 1'b0;
    mif.funct3 = 3'd0; mif.op_a = 32'd7; mif.op_b = 32'd6;
    sb.push_back('{res: 32'd42, cyc: c0 + 13});
    @(negedge clk);
    check("flush_cycle", cyc - c0, 32'd11);
    check("flush_busy", {31'b0, mif.busy}, 32'd0);
    check("flush_result_kept", mif.result, 32'hFFFF_FFFE);
    idle(1);
    mif.start = 1'b0;
    idle(4);

    // Start held across two ops
    run_op(3'd5, 32'd7, 32'd2, 32'd3, 34, 1'b0, 1'b1);
    run_op(3'd3, 32'h0001_0000, 32'h0001_0000, 32'h1, 2, 1'b0, 1'b0);
    idle(1);

    // Reset during a divide
    mif.start = 1'b1; mif.funct3 = 3'd4; mif.op_a = 32'd50; mif.op_b = 32'd5;
    idle(5);
    rst = 1'b1;
    mif.start = 1'b0;
    @(negedge clk);
    check("rst_mid_busy_hold", {31'b0, mif.busy}, 32'd1);
    @(negedge clk);
    check("rst_mid_result", mif.result, 32'h0);
    check("rst_mid_done", {31'b0, mif.done}, 32'd0);
    check("rst_mid_busy", {31'b0, mif.busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
    run_op(3'd4, 32'd50, 32'd5, 32'd10, 34, 1'b0, 1'b0);

    // Random ops against the reference model
    for (int i = 0; i < 8; i++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      if (i == 0) begin f3 = 3'd7; a = 32'hDEAD_BEEF; b = 32'd1; end
      run_op(f3, a, b, model(f3, a, b), latency(f3, a, b), 1'b0, 1'b0);
    end

    idle(3);
    check("sb_empty", sb.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
